interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Collects external interrupt lines, latches them as pending, masks and prioritises them, and presents a single held interrupt request to CP0. Source side of the CP0 `ExternalInterrupt` input: it raises the request, waits for CP0 to accept it at write-back, then blocks further requests until `eret` retires. Sits beside CP0 in the Minisys-1A top level; pending/ID outputs are also readable by the handler through the bus.

## Interface
Parameters:
- `N_IRQ`, 6, number of external interrupt lines (1..8)
- `HANDLER_ADDR`, 32'h0000F000, common exception/interrupt entry address driven on `handler_pc`

Ports:
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `irq_in`  in  N_IRQ  raw interrupt lines, active-high, may be asynchronous
- `status_ie`  in  1  CP0 global interrupt enable
- `status_im`  in  N_IRQ  CP0 per-line mask, 1 = enabled
- `int_ack`  in  1  one-cycle pulse: CP0 has taken the interrupt (EPC/Cause written)
- `eret`  in  1  one-cycle pulse: eret retired in write-back
- `int_req`  out  1  request to CP0 (drives `ExternalInterrupt`)
- `int_id`  out  3  index of the requested line, valid while `int_req`=1 and through SERVICE
- `int_pending`  out  N_IRQ  current pending register
- `handler_pc`  out  32  constant `HANDLER_ADDR`

## Operation
- Edge detect: `irq_q` registers the (synchronised) line; `rise = irq_s & ~irq_q`. Level-high lines produce one event only.
- Pending: `pending <= (pending & ~clr) | rise`; `clr` is one-hot of `int_id` on the `int_ack` cycle. Set wins over clear on the same bit in the same cycle.
- Eligible = `pending & status_im`, gated by `status_ie`. Priority: lowest index wins (line 0 highest).
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if `status_ie` and eligible ≠ 0 → REQ; latch winning index into `int_id`.
  - REQ: `int_req`=1, `int_id` frozen. Held regardless of later changes to `status_ie`/`status_im` or new higher-priority pendings. `int_ack` → SERVICE, clear that pending bit.
  - SERVICE: `int_req`=0, no new request. `eret` → IDLE. New events keep accumulating in `pending`.
- `eret` in IDLE or REQ: ignored. `int_ack` outside REQ: ignored, no pending bit cleared.
- `int_ack` and `eret` never assert together; if they do, `int_ack` handled, `eret` dropped.

## Timing
- Reset: state IDLE, `pending`=0, `irq_q`=0, synchroniser flops=0, `int_req`=0, `int_id`=0; `handler_pc`=`HANDLER_ADDR` always. Reset mid-REQ/SERVICE discards all pending and returns to IDLE next edge.
- `int_req`, `int_id`, `int_pending` are registered outputs.
- Latency (sync off): line first sampled high at edge k → `pending` bit set after edge k → `int_req`=1 after edge k+1.
- `int_ack` at edge m → `int_req`=0 and bit cleared after edge m.
- `eret` at edge e → IDLE after e; a still-eligible pending raises `int_req` after edge e+1.

## Configuration
- `INTC_IRQ_SYNC_EN` defined: two-flop synchroniser on every `irq_in` bit before edge detect; all input-to-pending latencies +2 cycles.
- Undefined: `irq_s = irq_in` directly; inputs must be synchronous to `clock`.

## Structure
- Shared package `cpu_defs`: FSM state encoding (IDLE/REQ/SERVICE), `HANDLER_ADDR` default, CP0 ExcCode constant for interrupt (5'b00000).
- One sub-module: `irq_prio_enc` — combinational N_IRQ lowest-index priority encoder returning index and valid flag.

## Test plan
- Reset, pulse `irq_in[2]`, ie=1, im=all ones → `pending`=000100 after edge k, `int_req`=1, `int_id`=2 after k+1; ack → `int_req`=0, pending=0.
- Lines 4 and 1 rise same cycle → `int_id`=1; after ack+eret, `int_id`=4 requested next.
- `status_im[3]`=0, line 3 rises → pending bit set, `int_req` stays 0; set im[3]=1 → `int_req`=1 next edge.
- In REQ, drop `status_ie` and raise line 0 → `int_req` held, `int_id` unchanged until ack.
- Line 5 rises on the same edge as `int_ack` for line 5 → bit 5 remains pending; in SERVICE no request until `eret`, then `int_req`=1, `int_id`=5.
- With `INTC_IRQ_SYNC_EN`: same as first case, `int_req` appears two cycles later; reset asserted in SERVICE → all outputs 0 after next edge.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// cpu_defs: shared CPU definitions used by the interrupt controller and CP0.
package cpu_defs;
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} intc_state_t;
   localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_F000;
   localparam logic [4:0]  EXC_CODE_INT     = 5'b00000;
endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: CP0 <-> interrupt controller signal bundle.
interface interrupt_controller_if #(
   parameter int N_IRQ = 6
);
   logic             status_ie;
   logic [N_IRQ-1:0] status_im;
   logic             int_ack;
   logic             eret;
   logic             int_req;
   logic [2:0]       int_id;
   logic [N_IRQ-1:0] int_pending;
   logic [31:0]      handler_pc;
   modport master (
      output status_ie, status_im, int_ack, eret,
      input  int_req, int_id, int_pending, handler_pc
   );
   modport slave (
      input  status_ie, status_im, int_ack, eret,
      output int_req, int_id, int_pending, handler_pc
   );
endinterface

// File: rtl/interrupt_controller_irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder with valid flag.
module irq_prio_enc #(
   parameter int N_IRQ = 6
) (
   input  logic [N_IRQ-1:0] i_req,
   output logic [2:0]       o_idx,
   output logic             o_valid
);
   always_comb begin
      o_idx   = '0;
      o_valid = |i_req;
      for (int i = N_IRQ - 1; i >= 0; i--)
         if (i_req[i]) o_idx = 3'(i);
   end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches, masks and prioritises IRQ lines into one held CP0 request.
// Define INTC_IRQ_SYNC_EN to add a two-flop synchroniser on every irq_in bit.
module interrupt_controller
   import cpu_defs::*;
#(
   parameter int          N_IRQ        = 6,
   parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_in,
   interrupt_controller_if.slave cp0
);
   logic [N_IRQ-1:0] w_irq_s, w_rise, w_elig, w_clr;
   logic [N_IRQ-1:0] r_irq_q, r_pending;
   logic [2:0]       w_win_id, w_id_nxt, r_int_id;
   logic             w_win_vld, w_req_nxt, r_int_req;
   intc_state_t      r_state, w_state_nxt;

`ifdef INTC_IRQ_SYNC_EN
   logic [N_IRQ-1:0] r_sync1, r_sync2;
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= irq_in;
         r_sync2 <= r_sync1;
      end
   end
   assign w_irq_s = r_sync2;
`else
   assign w_irq_s = irq_in;
`endif

   assign w_rise = w_irq_s & ~r_irq_q;
   assign w_elig = r_pending & cp0.status_im;

   irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
      .i_req   (w_elig),
      .o_idx   (w_win_id),
      .o_valid (w_win_vld)
   );

   // Once raised, the request and its id are frozen until CP0 acknowledges.
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_int_req;
      w_id_nxt    = r_int_id;
      w_clr       = '0;
      case (r_state)
         ST_IDLE: if (cp0.status_ie && w_win_vld) begin
            w_state_nxt = ST_REQ;
            w_req_nxt   = 1'b1;
            w_id_nxt    = w_win_id;
         end
         ST_REQ: if (cp0.int_ack) begin
            w_state_nxt = ST_SERVICE;
            w_req_nxt   = 1'b0;
            w_clr       = N_IRQ'(1) << r_int_id;
         end
         ST_SERVICE: w_state_nxt = cp0.eret ? ST_IDLE : ST_SERVICE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_irq_q   <= '0;
         r_pending <= '0;
         r_int_req <= 1'b0;
         r_int_id  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_irq_q   <= w_irq_s;
         r_pending <= (r_pending & ~w_clr) | w_rise;
         r_int_req <= w_req_nxt;
         r_int_id  <= w_id_nxt;
      end
   end

   assign cp0.int_req     = r_int_req;
   assign cp0.int_id      = r_int_id;
   assign cp0.int_pending = r_pending;
   assign cp0.handler_pc  = HANDLER_ADDR;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed scoreboard bench for interrupt_controller.
module tb_interrupt_controller;
`ifdef INTC_IRQ_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int N = 6;

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] irq_in;
   int           n_chk = 0;
   int           n_err = 0;
   logic [2:0]   exp_q[$];

   interrupt_controller_if #(.N_IRQ(N)) cp0_if ();

   interrupt_controller #(.N_IRQ(N), .HANDLER_ADDR(32'h0000_F000)) dut (
      .clock  (clock),
      .reset  (reset),
      .irq_in (irq_in),
      .cp0    (cp0_if)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, required finish before 100000");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic got_req(input string tag);
      chk({tag, "_req"}, 32'(cp0_if.int_req), 1);
      chk({tag, "_sb_has_entry"}, 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk({tag, "_id"}, 32'(cp0_if.int_id), 32'(exp_q.pop_front()));
   endtask

   task automatic pulse_ack();
      cp0_if.int_ack = 1'b1;
      step(1);
      cp0_if.int_ack = 1'b0;
   endtask

   task automatic pulse_eret();
      cp0_if.eret = 1'b1;
      step(1);
      cp0_if.eret = 1'b0;
   endtask

   initial begin
      reset            = 1'b1;
      irq_in           = '0;
      cp0_if.status_ie = 1'b0;
      cp0_if.status_im = '0;
      cp0_if.int_ack   = 1'b0;
      cp0_if.eret      = 1'b0;
      step(2);
      chk("rst_req", 32'(cp0_if.int_req), 0);
      chk("rst_id", 32'(cp0_if.int_id), 0);
      chk("rst_pend", 32'(cp0_if.int_pending), 0);
      chk("rst_pc", cp0_if.handler_pc, 32'h0000_F000);
      reset            = 1'b0;
      cp0_if.status_ie = 1'b1;
      cp0_if.status_im = '1;
      step(1);
      // single line 2
      irq_in = 6'b000100;
      exp_q.push_back(3'd2);
      step(1);
      irq_in = '0;
      step(SYNC);
      chk("t1_pend", 32'(cp0_if.int_pending), 32'h04);
      chk("t1_noreq_yet", 32'(cp0_if.int_req), 0);
      step(1);
      got_req("t1");
      pulse_ack();
      chk("t1_ack_req", 32'(cp0_if.int_req), 0);
      chk("t1_ack_pend", 32'(cp0_if.int_pending), 0);
      pulse_eret();
      // lines 4 and 1 together: 1 first, then 4
      irq_in = 6'b010010;
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd4);
      step(1);
      irq_in = '0;
      step(SYNC);
      chk("t2_pend", 32'(cp0_if.int_pending), 32'h12);
      step(1);
      got_req("t2a");
      pulse_ack();
      chk("t2_ack_pend", 32'(cp0_if.int_pending), 32'h10);
      step(2);
      chk("t2_service_noreq", 32'(cp0_if.int_req), 0);
      pulse_eret();
      chk("t2_eret_noreq", 32'(cp0_if.int_req), 0);
      step(1);
      got_req("t2b");
      pulse_ack();
      pulse_eret();
      // masked line 3, then unmask
      cp0_if.status_im = 6'b110111;
      irq_in = 6'b001000;
      step(1);
      irq_in = '0;
      step(SYNC);
      chk("t3_pend", 32'(cp0_if.int_pending), 32'h08);
      step(2);
      chk("t3_masked_noreq", 32'(cp0_if.int_req), 0);
      cp0_if.status_im = '1;
      exp_q.push_back(3'd3);
      step(1);
      got_req("t3");
      // request held across ie drop and higher-priority arrival
      cp0_if.status_ie = 1'b0;
      irq_in = 6'b000001;
      step(1);
      irq_in = '0;
      step(SYNC);
      chk("t4_pend", 32'(cp0_if.int_pending), 32'h09);
      step(1);
      chk("t4_held_req", 32'(cp0_if.int_req), 1);
      chk("t4_held_id", 32'(cp0_if.int_id), 3);
      pulse_ack();
      chk("t4_ack_req", 32'(cp0_if.int_req), 0);
      chk("t4_ack_pend", 32'(cp0_if.int_pending), 32'h01);
      pulse_eret();
      step(1);
      chk("t4_ie_off_noreq", 32'(cp0_if.int_req), 0);
      cp0_if.status_ie = 1'b1;
      exp_q.push_back(3'd0);
      step(1);
      got_req("t4");
      pulse_ack();
      pulse_eret();
      // line 5 re-rises on its own ack edge
      irq_in = 6'b100000;
      exp_q.push_back(3'd5);
      step(1);
      irq_in = '0;
      step(SYNC);
      step(1);
      got_req("t5a");
      irq_in = 6'b100000;
      exp_q.push_back(3'd5);
      step(SYNC);
      pulse_ack();
      irq_in = '0;
      chk("t5_set_wins", 32'(cp0_if.int_pending), 32'h20);
      chk("t5_ack_req", 32'(cp0_if.int_req), 0);
      step(3);
      chk("t5_service_noreq", 32'(cp0_if.int_req), 0);
      pulse_eret();
      chk("t5_eret_noreq", 32'(cp0_if.int_req), 0);
      step(1);
      got_req("t5b");
      // reset while in SERVICE with a new pending line
      pulse_ack();
      irq_in = 6'b000010;
      step(1);
      irq_in = '0;
      step(SYNC);
      chk("t6_pend", 32'(cp0_if.int_pending), 32'h02);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("t6_rst_req", 32'(cp0_if.int_req), 0);
      chk("t6_rst_id", 32'(cp0_if.int_id), 0);
      chk("t6_rst_pend", 32'(cp0_if.int_pending), 0);
      step(3);
      chk("t6_idle_noreq", 32'(cp0_if.int_req), 0);
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
